// File: rtl/vdma_video_pkg.sv
// Shared types for the VDMA video path: timing FSM states, counter and
// coordinate widths, the window configuration payload and a raster total helper.
package vdma_video_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned CNT_W   = 13;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } timing_state_e;

  // Window rectangle as presented by the register block.
  typedef struct packed {
    coord_t top;
    coord_t left;
    coord_t width;
    coord_t height;
  } win_cfg_t;

  // Total clocks per line (or lines per frame) from its four regions.
  function automatic int unsigned timing_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/win_region_cmp.sv
// Window region comparator: latches the window bounds on load and flags
// whether the current raster position lies inside the clipped rectangle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture cfg into the bound registers
//   cfg           window top/left/width/height
//   hcnt, vcnt    current raster position
//   in_win_c      combinational: position inside latched window
module win_region_cmp
  import vdma_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  win_cfg_t cfg,
  input  cnt_t     hcnt,
  input  cnt_t     vcnt,
  output logic     in_win_c
);

  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE - 1);

  cnt_t left_q;
  cnt_t top_q;
  cnt_t x_end_q;
  cnt_t y_end_q;
  cnt_t x_end;
  cnt_t y_end;

  // Inclusive end coordinate; size 0 means "to the end of the active span".
  // Clipped to the last active coordinate; a start beyond it leaves end < start,
  // so the window simply never matches.
  function automatic cnt_t span_end(input coord_t start, input coord_t size,
                                    input cnt_t last);
    cnt_t ext;
    cnt_t sum;
    ext = (size != '0) ? (cnt_t'(size) - cnt_t'(1)) : last;
    sum = cnt_t'(start) + ext;
    return (sum > last) ? last : sum;
  endfunction

  assign x_end = span_end(cfg.left, cfg.width,  H_LAST);
  assign y_end = span_end(cfg.top,  cfg.height, V_LAST);

  // Bound registers, updated only at frame boundaries chosen by the parent.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_q  <= '0;
      top_q   <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (load) begin
      left_q  <= cnt_t'(cfg.left);
      top_q   <= cnt_t'(cfg.top);
      x_end_q <= x_end;
      y_end_q <= y_end;
    end
  end

  assign in_win_c = (hcnt >= left_q) && (hcnt <= x_end_q) &&
                    (vcnt >= top_q)  && (vcnt <= y_end_q);

endmodule

// File: rtl/window_timing_gen.sv
// Video timing source: full-frame vsync/hsync/de plus win_de over a
// programmable rectangle latched at frame boundaries.
// Ports:
//   pclk, prst          pixel clock, synchronous active-high reset
//   enable              1: run frames, 0: stop at end of current frame
//   win_top/left        window first line / first pixel
//   win_width/height    window size, 0 = to end of active area
//   outvsync/outhsync   syncs with VS_POL/HS_POL polarity
//   outde               full-frame active video
//   win_de              outde inside latched window
//   sof                 pulse on first active pixel of a frame
//   busy                generator not idle
module window_timing_gen
  import vdma_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic               enable,
  input  logic [COORD_W-1:0] win_top,
  input  logic [COORD_W-1:0] win_left,
  input  logic [COORD_W-1:0] win_width,
  input  logic [COORD_W-1:0] win_height,
  output logic               outvsync,
  output logic               outhsync,
  output logic               outde,
  output logic               win_de,
  output logic               sof,
  output logic               busy
);

  localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_ACT_C    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C    = cnt_t'(V_ACTIVE);
  localparam cnt_t H_LAST_C   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST_C   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HS_START_C = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END_C   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START_C = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END_C   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  timing_state_e state_q;
  timing_state_e state_d;
  cnt_t          hcnt_q;
  cnt_t          hcnt_d;
  cnt_t          vcnt_q;
  cnt_t          vcnt_d;
  cnt_t          hcnt_adv;
  cnt_t          vcnt_adv;
  logic          line_last;
  logic          frame_last;
  logic          load_win;
  logic          running;
  logic          de_act;
  logic          hs_act;
  logic          vs_act;
  logic          in_win;
  win_cfg_t      win_cfg;

  assign win_cfg = '{top: win_top, left: win_left, width: win_width, height: win_height};

  // Free-running raster advance; only applied outside IDLE.
  assign line_last  = (hcnt_q == H_LAST_C);
  assign frame_last = line_last && (vcnt_q == V_LAST_C);
  assign hcnt_adv   = line_last ? '0 : hcnt_q + cnt_t'(1);
  assign vcnt_adv   = !line_last ? vcnt_q :
                      (frame_last ? '0 : vcnt_q + cnt_t'(1));

  // State and raster counter registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Next state, next counters and window latch strobe.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = '0;
    vcnt_d   = '0;
    load_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = RUN;
          load_win = 1'b1;
        end
      end
      RUN: begin
        hcnt_d = hcnt_adv;
        vcnt_d = vcnt_adv;
        if (!enable) begin
          // Dropping enable on the very last pixel ends the frame right here.
          state_d = frame_last ? IDLE : STOP;
        end else if (frame_last) begin
          load_win = 1'b1;
        end
      end
      STOP: begin
        hcnt_d = hcnt_adv;
        vcnt_d = vcnt_adv;
        if (enable) begin
          state_d  = RUN;
          load_win = frame_last;
        end else if (frame_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  win_region_cmp #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_win_cmp (
    .clk      (pclk),
    .rst      (prst),
    .load     (load_win),
    .cfg      (win_cfg),
    .hcnt     (hcnt_q),
    .vcnt     (vcnt_q),
    .in_win_c (in_win)
  );

  // Raster decode of the current counter state.
  assign running = (state_q != IDLE);
  assign de_act  = running && (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
  assign hs_act  = running && (hcnt_q >= HS_START_C) && (hcnt_q < HS_END_C);
  assign vs_act  = running && (vcnt_q >= VS_START_C) && (vcnt_q < VS_END_C);

  // Output registers: one pclk behind the decoded counter state.
  always_ff @(posedge pclk) begin
    if (prst) begin
      outvsync <= ~VS_POL;
      outhsync <= ~HS_POL;
      outde    <= 1'b0;
      win_de   <= 1'b0;
      sof      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      outvsync <= vs_act ? VS_POL : ~VS_POL;
      outhsync <= hs_act ? HS_POL : ~HS_POL;
      outde    <= de_act;
      win_de   <= de_act && in_win;
      sof      <= de_act && (hcnt_q == '0) && (vcnt_q == '0);
      busy     <= running;
    end
  end

endmodule
